// File: rtl/depth_test_writer_if.sv
// Pixel-stream, depth-BRAM and framebuffer signals of depth_test_writer.
// master: rasterizer/BRAM/framebuffer side; slave: the depth_test_writer itself.
interface depth_test_writer_if #(
  parameter int unsigned DATAWIDTH  = 12,
  parameter int unsigned COLORWIDTH = 4,
  parameter int unsigned ADDRWIDTH  = 16
) ();
  logic [ADDRWIDTH-1:0]  i_fb_addr;
  logic                  i_fb_write_en;
  logic [DATAWIDTH-1:0]  i_depth;
  logic [COLORWIDTH-1:0] i_color;
  logic                  i_done;
  logic                  i_clear;
  logic                  o_ready;
  logic [ADDRWIDTH-1:0]  o_zb_raddr;
  logic [DATAWIDTH-1:0]  i_zb_rdata;
  logic [ADDRWIDTH-1:0]  o_zb_waddr;
  logic                  o_zb_we;
  logic [DATAWIDTH-1:0]  o_zb_wdata;
  logic [ADDRWIDTH-1:0]  o_fb_addr;
  logic                  o_fb_we;
  logic [COLORWIDTH-1:0] o_fb_color;
  logic                  o_done;
  logic                  o_clear_done;

  modport slave (
    input  i_fb_addr, i_fb_write_en, i_depth, i_color, i_done, i_clear, i_zb_rdata,
    output o_ready, o_zb_raddr, o_zb_waddr, o_zb_we, o_zb_wdata,
    output o_fb_addr, o_fb_we, o_fb_color, o_done, o_clear_done
  );

  modport master (
    output i_fb_addr, i_fb_write_en, i_depth, i_color, i_done, i_clear, i_zb_rdata,
    input  o_ready, o_zb_raddr, o_zb_waddr, o_zb_we, o_zb_wdata,
    input  o_fb_addr, o_fb_we, o_fb_color, o_done, o_clear_done
  );
endinterface

// File: rtl/depth_test_writer.sv
// Depth-test writer: read-modify-write of an external read-first depth BRAM
// with two-slot write forwarding, colour write for nearer pixels, and a
// full-buffer depth clear sweep.
// Optional macro FB_CLEAR_COLOR_EN: clear sweep also writes colour 0 to the framebuffer.
module depth_test_writer #(
  parameter int unsigned DATAWIDTH  = 12,
  parameter int unsigned COLORWIDTH = 4,
  parameter int unsigned ADDRWIDTH  = 16,
  parameter int unsigned FB_SIZE    = 19200
) (
  input logic               clk,
  input logic               rst,
  depth_test_writer_if.slave bus
);

  // Counter is one bit wider so FB_SIZE == 2**ADDRWIDTH compares correctly
  localparam int unsigned CNTW = ADDRWIDTH + 1;

  typedef enum logic [1:0] {IDLE, CLEAR, CDONE} state_t;

  state_t                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDRWIDTH-1:0]  s1_addr_q, s1_addr_d;
  logic [DATAWIDTH-1:0]  s1_depth_q, s1_depth_d;
  logic [COLORWIDTH-1:0] s1_color_q, s1_color_d;
  logic                  zb_we_q, zb_we_d;
  logic [ADDRWIDTH-1:0]  zb_waddr_q, zb_waddr_d;
  logic [DATAWIDTH-1:0]  zb_wdata_q, zb_wdata_d;
  logic                  fb_we_q, fb_we_d;
  logic [ADDRWIDTH-1:0]  fb_addr_q, fb_addr_d;
  logic [COLORWIDTH-1:0] fb_color_q, fb_color_d;
  logic                  w2_we_q, w2_we_d;
  logic [ADDRWIDTH-1:0]  w2_addr_q, w2_addr_d;
  logic [DATAWIDTH-1:0]  w2_data_q, w2_data_d;
  logic                  done1_q, done1_d;
  logic                  done2_q, done2_d;
  logic                  clear_done_q, clear_done_d;

  logic                  accept_c;
  logic                  w1_hit_c;
  logic                  w2_hit_c;
  logic [DATAWIDTH-1:0]  stored_c;
  logic                  pass_c;

  // Depth read goes straight to the BRAM in the accept cycle
  assign bus.o_zb_raddr   = bus.i_fb_addr;
  assign bus.o_ready      = ready_q;
  assign bus.o_zb_we      = zb_we_q;
  assign bus.o_zb_waddr   = zb_waddr_q;
  assign bus.o_zb_wdata   = zb_wdata_q;
  assign bus.o_fb_we      = fb_we_q;
  assign bus.o_fb_addr    = fb_addr_q;
  assign bus.o_fb_color   = fb_color_q;
  assign bus.o_done       = done2_q;
  assign bus.o_clear_done = clear_done_q;

  // Stage-1 capture, stored-depth forwarding and the strict nearer test
  always_comb begin
    accept_c   = ready_q & bus.i_fb_write_en;
    s1_valid_d = accept_c;
    s1_addr_d  = bus.i_fb_addr;
    s1_depth_d = bus.i_depth;
    s1_color_d = bus.i_color;
    w1_hit_c   = zb_we_q && (zb_waddr_q == s1_addr_q);
    w2_hit_c   = w2_we_q && (w2_addr_q == s1_addr_q);
    if (w1_hit_c) begin
      stored_c = zb_wdata_q;
    end else if (w2_hit_c) begin
      stored_c = w2_data_q;
    end else begin
      stored_c = bus.i_zb_rdata;
    end
    pass_c  = s1_valid_q && (s1_depth_q < stored_c);
    done1_d = bus.i_done;
    done2_d = done1_q;
  end

  // Next state, clear sweep and registered write-port values
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    cnt_d        = cnt_q;
    ready_d      = 1'b0;
    clear_done_d = 1'b0;
    zb_we_d      = pass_c;
    zb_waddr_d   = s1_addr_q;
    zb_wdata_d   = s1_depth_q;
    fb_we_d      = pass_c;
    fb_addr_d    = s1_addr_q;
    fb_color_d   = s1_color_q;
    w2_we_d      = zb_we_q;
    w2_addr_d    = zb_waddr_q;
    w2_data_d    = zb_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_clear) begin
          pend_d = 1'b1;
        end
        // Start only once the last accepted pixel has left S1 and W1
        if (pend_q && !s1_valid_q && !zb_we_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
        ready_d = (state_d == IDLE) && !pend_d;
      end
      CLEAR: begin
        zb_we_d    = 1'b1;
        zb_waddr_d = ADDRWIDTH'(cnt_q);
        zb_wdata_d = '1;
`ifdef FB_CLEAR_COLOR_EN
        fb_we_d    = 1'b1;
        fb_addr_d  = ADDRWIDTH'(cnt_q);
        fb_color_d = COLORWIDTH'(0);
`else
        fb_we_d    = 1'b0;
`endif
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(FB_SIZE - 1)) begin
          state_d = CDONE;
        end
      end
      CDONE: begin
        zb_we_d      = 1'b0;
        fb_we_d      = 1'b0;
        w2_we_d      = 1'b0;
        pend_d       = 1'b0;
        clear_done_d = 1'b1;
        state_d      = IDLE;
        ready_d      = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_depth_q   <= '0;
      s1_color_q   <= '0;
      zb_we_q      <= 1'b0;
      zb_waddr_q   <= '0;
      zb_wdata_q   <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_color_q   <= '0;
      w2_we_q      <= 1'b0;
      w2_addr_q    <= '0;
      w2_data_q    <= '0;
      done1_q      <= 1'b0;
      done2_q      <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s1_depth_q   <= s1_depth_d;
      s1_color_q   <= s1_color_d;
      zb_we_q      <= zb_we_d;
      zb_waddr_q   <= zb_waddr_d;
      zb_wdata_q   <= zb_wdata_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_color_q   <= fb_color_d;
      w2_we_q      <= w2_we_d;
      w2_addr_q    <= w2_addr_d;
      w2_data_q    <= w2_data_d;
      done1_q      <= done1_d;
      done2_q      <= done2_d;
      clear_done_q <= clear_done_d;
    end
  end

endmodule
